hilo_sequencer: RTL

Iterative multiply/divide sequencer that owns the HI/LO register pair for the single-cycle MIPS core. It replaces the combinational multiplier and HI/LO flop with a 32-iteration shift-add multiplier (MULTU) and restoring divider (DIVU). It also generates the stall that holds the core whenever an instruction needs HI/LO or the unit while an operation is in flight. The block sits beside the ALU in the datapath: it takes operands from srca/srcb and control from the main decoder, and its rd_data feeds the result mux in the HI/LO slot.

---
 rtl/hilo_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hilo_sequencer.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add MULTU and restoring DIVU.
// Owns the architectural HI/LO pair and stalls the core while an operation is in flight.
module hilo_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             rd_req,
  input  logic             rd_hi,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  // MULTU: accumulator {hi_part, multiplier}; DIVU: {rem, quot}. Both are 2*WIDTH+1 bits.
  logic [2*WIDTH:0] work, work_next;
  logic [WIDTH-1:0] operand;   // multiplicand (MULTU) or divisor (DIVU)
  logic             op_div;
  logic             load, finish;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH:0] shifted;

  // One iteration of whichever algorithm is in flight.
  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    sum       = '0;
    trial     = '0;
    shifted   = '0;
    work_next = work;
    if (!op_div) begin
      sum = work[2*WIDTH:WIDTH] + {1'b0, operand};
      work_next = {1'b0, (work[0] ? sum : work[2*WIDTH:WIDTH]), work[WIDTH-1:1]};
    end else begin
      shifted = {work[2*WIDTH-1:0], 1'b0};
      trial   = shifted[2*WIDTH:WIDTH] - {1'b0, operand};
      if (!trial[WIDTH]) begin
        work_next = {trial, shifted[WIDTH-1:1], 1'b1};
      end else begin
        work_next = shifted;
      end
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (count == LAST) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the working registers are cleared on reset too, so an aborted operation leaves no residue.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      work     <= '0;
      operand  <= '0;
      op_div   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        count   <= '0;
        work    <= {{(WIDTH+1){1'b0}}, (op ? srca : srcb)};
        operand <= op ? srcb : srca;
        op_div  <= op;
      end else if (state == RUN) begin
        count <= count + 1'b1;
        work  <= work_next;
        // Both algorithms leave HI in the upper half and LO in the lower half.
        if (finish) begin
          hi       <= work_next[2*WIDTH-1:WIDTH];
          lo       <= work_next[WIDTH-1:0];
          div_zero <= op_div && (operand == '0);
        end
      end
    end
  end

  assign busy    = (state == RUN);
  assign stall   = busy & (start | rd_req);
  assign rd_data = rd_hi ? hi : lo;

endmodule
